// File: rtl/result_drain.sv
// Snapshots the per-PE result bus on each accelerator completion and streams it
// to the host as WORD_SIZE-bit words over a valid/ready interface.
module result_drain #(
  parameter int unsigned WORD_SIZE = 64,
  parameter int unsigned NUM_PES   = 64,
  parameter int unsigned BIPOLAR   = 0,
  parameter int unsigned DOT_LEN   = 4096
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    done,
  input  logic [NUM_PES*16-1:0]   results_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORD_SIZE-1:0]    out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    overrun
);

  localparam int unsigned R     = WORD_SIZE / 16;
  localparam int unsigned NW    = (NUM_PES + R - 1) / R;
  localparam int unsigned CW    = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned NSLOT = 2 ** CW;
  localparam logic [15:0]    DL       = 16'(DOT_LEN);
  localparam logic [CW-1:0]  LAST_IDX = CW'(NW - 1);

  typedef enum logic [0:0] {
    S_IDLE,
    S_SEND
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_done_q;
  logic                 r_overrun;
  logic [CW-1:0]        r_cnt;
  logic [15:0]          r_snap  [NUM_PES];
  logic [15:0]          w_conv  [NUM_PES];
  logic [WORD_SIZE-1:0] w_words [NSLOT];
  logic                 w_done_rise;
  logic                 w_capture;
  logic                 w_xfer;
  logic                 w_last;

  assign w_done_rise = done & ~r_done_q;
  assign w_last      = (r_cnt == LAST_IDX);

  // Bipolar mapping 2*p - DOT_LEN, wrapped to 16 bits.
  always_comb begin
    for (int unsigned i = 0; i < NUM_PES; i++) begin
      w_conv[i] = results_in[i*16 +: 16];
      if (BIPOLAR != 0) begin
        w_conv[i] = {results_in[i*16 +: 15], 1'b0} - DL;
      end
    end
  end

  // Word table padded to a power of two so r_cnt indexes it exactly; slots past NUM_PES read zero.
  always_comb begin
    for (int unsigned w = 0; w < NSLOT; w++) begin
      w_words[w] = '0;
      for (int unsigned j = 0; j < R; j++) begin
        if (w * R + j < NUM_PES) begin
          w_words[w][j*16 +: 16] = r_snap[w * R + j];
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_xfer      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_done_rise) begin
          w_capture   = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (out_ready) begin
          w_xfer = 1'b1;
          if (w_last) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_done_q  <= 1'b0;
      r_overrun <= 1'b0;
      r_cnt     <= '0;
      for (int unsigned i = 0; i < NUM_PES; i++) begin
        r_snap[i] <= '0;
      end
    end else begin
      r_state   <= w_state_nxt;
      r_done_q  <= done;
      r_overrun <= w_done_rise & (r_state == S_SEND);
      if (w_capture) begin
        r_cnt <= '0;
        for (int unsigned i = 0; i < NUM_PES; i++) begin
          r_snap[i] <= w_conv[i];
        end
      end else if (w_xfer && !w_last) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign out_valid = (r_state == S_SEND);
  assign busy      = out_valid;
  assign out_last  = out_valid & w_last;
  assign out_data  = out_valid ? w_words[r_cnt] : '0;
  assign overrun   = r_overrun;

endmodule
